// File: rtl/instr_issue_seq.sv
// ---------------------------------------------------------------------------
// instr_issue_seq
//
// Program sequencer for the CPU execute path. The host fills a program
// buffer with {opcode, operand1, operand2} words, then pulses start. Each
// word is offered to the CPU over a valid/ready handshake. The sequencer
// waits for that instruction's result, stores it in a result buffer the host
// can read back, and pulses done when the program is complete.
//
// Optional feature (compile-time macro DIV0_TRAP_EN):
//   When defined, a divide (opcode 11) whose operand2 is zero is never
//   offered to the CPU. The sequencer writes all-ones into the result entry,
//   sets the sticky err_div0 flag and moves on after one cycle. Without the
//   macro, such instructions are issued normally and err_div0 stays 0.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   prog_we/addr/data host write port into the program buffer (idle only)
//   prog_len          instruction count, sampled on start, clamped to DEPTH
//   start             begin execution at entry 0 (ignored unless idle)
//   busy, done        run in progress; one-cycle completion pulse
//   issue_*           instruction handshake toward the CPU
//   res_valid/data    CPU result return
//   res_rd_addr/data  combinational host read of the result buffer
//   err_div0          sticky divide-by-zero trap flag
// ---------------------------------------------------------------------------
module instr_issue_seq #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [2*DATA_W+1:0]   prog_data,
  input  logic [AW:0]           prog_len,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [1:0]            issue_opcode,
  output logic [DATA_W-1:0]     issue_operand1,
  output logic [DATA_W-1:0]     issue_operand2,
  input  logic                  res_valid,
  input  logic [DATA_W-1:0]     res_data,
  input  logic [AW-1:0]         res_rd_addr,
  output logic [DATA_W-1:0]     res_rd_data,
  output logic                  err_div0
);

  localparam int unsigned WORD_W = 2 + 2 * DATA_W;
  localparam int unsigned LEN_W  = AW + 1;
  localparam logic [1:0]  OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state;
  logic [AW-1:0]       pc;
  logic [LEN_W-1:0]    len;

  logic [WORD_W-1:0]   prog_mem [DEPTH];
  logic [DATA_W-1:0]   res_mem  [DEPTH];

  logic [LEN_W-1:0]    len_clamped_c;
  logic                last_c;
  logic [AW-1:0]       fetch_idx_c;
  logic [WORD_W-1:0]   fetch_word_c;
  logic [1:0]          fetch_op_c;
  logic [DATA_W-1:0]   fetch_a_c;
  logic [DATA_W-1:0]   fetch_b_c;
  logic                fetch_trap_c;
  logic                cur_trap_c;
  logic                res_we_c;
  logic [DATA_W-1:0]   res_wdata_c;
  logic                handshake_c;

  // Fetch of the next instruction word: entry 0 on start, pc+1 on advance.
  always_comb begin
    len_clamped_c = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    last_c        = ({1'b0, pc} == (len - LEN_W'(1)));
    fetch_idx_c   = (state == S_IDLE) ? '0 : (pc + AW'(1));
    fetch_word_c  = prog_mem[fetch_idx_c];
    fetch_op_c    = fetch_word_c[WORD_W-1 -: 2];
    fetch_a_c     = fetch_word_c[2*DATA_W-1 -: DATA_W];
    fetch_b_c     = fetch_word_c[DATA_W-1:0];
    handshake_c   = (state == S_ISSUE) && issue_valid && issue_ready;
  end

  // Divide-by-zero detection for the word being loaded and the one held.
`ifdef DIV0_TRAP_EN
  always_comb begin
    fetch_trap_c = (fetch_op_c == OP_DIV) && (fetch_b_c == '0);
    cur_trap_c   = (state == S_ISSUE) && (issue_opcode == OP_DIV) &&
                   (issue_operand2 == '0);
  end
`else
  always_comb begin
    fetch_trap_c = 1'b0;
    cur_trap_c   = 1'b0;
  end
`endif

  // A trapped divide completes in ISSUE as though its result had arrived.
  always_comb begin
    res_we_c    = ((state == S_WAIT) && res_valid) || cur_trap_c;
    res_wdata_c = cur_trap_c ? '1 : res_data;
  end

  // Program buffer: host writes only while idle, so a run sees a fixed program.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  // Result buffer: one entry per completed instruction, indexed by pc.
  always_ff @(posedge clk) begin
    if (res_we_c) begin
      res_mem[pc] <= res_wdata_c;
    end
  end

  assign res_rd_data = res_mem[res_rd_addr];

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      pc             <= '0;
      len            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      issue_valid    <= 1'b0;
      issue_opcode   <= '0;
      issue_operand1 <= '0;
      issue_operand2 <= '0;
      err_div0       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len      <= len_clamped_c;
            pc       <= '0;
            err_div0 <= 1'b0;
            if (len_clamped_c == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state          <= S_ISSUE;
              busy           <= 1'b1;
              issue_opcode   <= fetch_op_c;
              issue_operand1 <= fetch_a_c;
              issue_operand2 <= fetch_b_c;
              issue_valid    <= ~fetch_trap_c;
            end
          end
        end

        S_ISSUE, S_WAIT: begin
          if (cur_trap_c) begin
            err_div0 <= 1'b1;
          end
          if (res_we_c) begin
            if (last_c) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc             <= pc + AW'(1);
              state          <= S_ISSUE;
              issue_opcode   <= fetch_op_c;
              issue_operand1 <= fetch_a_c;
              issue_operand2 <= fetch_b_c;
              issue_valid    <= ~fetch_trap_c;
            end
          end else if (handshake_c) begin
            issue_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_seq
//
// Directed bench for instr_issue_seq. Stimulus pushes each instruction word
// it expects to see issued into a queue; an independent monitor pops and
// compares on every issue handshake and also acts as the CPU, returning the
// arithmetic result one cycle later. Result buffer contents, done/busy
// behaviour and the div-by-zero flag are checked against bench-side values.
// ---------------------------------------------------------------------------
module tb_instr_issue_seq;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned WORD_W = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prog_we = 1'b0;
  logic [AW-1:0]     prog_addr = '0;
  logic [WORD_W-1:0] prog_data = '0;
  logic [AW:0]       prog_len = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              issue_valid;
  logic              issue_ready = 1'b1;
  logic [1:0]        issue_opcode;
  logic [DATA_W-1:0] issue_operand1;
  logic [DATA_W-1:0] issue_operand2;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic [AW-1:0]     res_rd_addr = '0;
  logic [DATA_W-1:0] res_rd_data;
  logic              err_div0;

  instr_issue_seq #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_len       (prog_len),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_opcode   (issue_opcode),
    .issue_operand1 (issue_operand1),
    .issue_operand2 (issue_operand2),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_rd_addr    (res_rd_addr),
    .res_rd_data    (res_rd_data),
    .err_div0       (err_div0)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] shadow [DEPTH];
  logic [7:0]        exp_res [DEPTH];
  bit                written [DEPTH];
  int                hs_seen = 0;
  int                hs_served = 0;
  int                done_cnt = 0;
  logic [7:0]        cpu_res = '0;
  int                stall_cfg = 0;
  bit                stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu(input logic [WORD_W-1:0] w);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    a = w[15:8];
    b = w[7:0];
    case (w[17:16])
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      default: r = (b == 8'd0) ? 8'hFF : a / b;
    endcase
    return r;
  endfunction

  function automatic bit is_trap(input logic [WORD_W-1:0] w);
    bit en;
`ifdef DIV0_TRAP_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (w[17:16] == 2'b11) && (w[7:0] == 8'd0);
  endfunction

  // Monitor and CPU front: checks every handshake against the expected queue.
  initial begin : monitor
    logic [WORD_W-1:0] prev_w;
    logic [WORD_W-1:0] cur_w;
    logic [WORD_W-1:0] e;
    bit                prev_stall;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      cur_w = {issue_opcode, issue_operand1, issue_operand2};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        if (prev_stall) begin
          chk("issue_hold", 32'({issue_valid, cur_w}), 32'({1'b1, prev_w}));
        end
        if (issue_valid && issue_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got 0x%0h, expected no issue", cur_w);
          end else begin
            e = exp_q.pop_front();
            chk("issue_word", 32'(cur_w), 32'(e));
          end
          cpu_res = alu(cur_w);
          hs_seen++;
        end
        prev_stall = issue_valid && !issue_ready;
        prev_w     = cur_w;
      end
    end
  end

  // CPU back end: ready with optional stall, 1-cycle result, optional stray res_valid.
  initial begin : cpu_driver
    int vcnt;
    vcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!issue_valid) vcnt = 0;
      issue_ready = issue_valid ? (vcnt >= stall_cfg) : 1'b1;
      if (issue_valid) vcnt++;
      if (hs_seen != hs_served) begin
        res_valid = 1'b1;
        res_data  = cpu_res;
        hs_served = hs_seen;
      end else if (stray_en && issue_valid && !issue_ready) begin
        res_valid = 1'b1;
        res_data  = 8'hEE;
      end else begin
        res_valid = 1'b0;
        res_data  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    prog_addr = AW'(addr);
    prog_data = {op, a, b};
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
    shadow[addr] = {op, a, b};
  endtask

  task automatic check_results();
    for (int i = 0; i < DEPTH; i++) begin
      if (written[i]) begin
        res_rd_addr = AW'(i);
        #1;
        chk($sformatf("res_mem[%0d]", i), 32'(res_rd_data), 32'(exp_res[i]));
      end
    end
  endtask

  task automatic read_res(input int addr, input logic [7:0] exp);
    res_rd_addr = AW'(addr);
    #1;
    chk($sformatf("res_const[%0d]", addr), 32'(res_rd_data), 32'(exp));
  endtask

  task automatic run(input int len, input int stall, input bit stray, input bit disturb);
    int n;
    int d0;
    bit busy_bad;
    bit got_done;
    bit any_trap;
    n = (len > DEPTH) ? DEPTH : len;
    any_trap = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (is_trap(shadow[i])) any_trap = 1'b1;
      else exp_q.push_back(shadow[i]);
      exp_res[i] = alu(shadow[i]);
      written[i] = 1'b1;
    end
    stall_cfg = stall;
    stray_en  = stray;
    d0        = done_cnt;
    prog_len  = (AW+1)'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    busy_bad  = 1'b0;
    got_done  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("err_cleared_on_start", 32'(err_div0), 32'd0);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (disturb && cyc == 3) begin
        start     = 1'b1;
        prog_len  = (AW+1)'(1);
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 18'h3_0000;
      end else if (disturb && cyc == 4) begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
    end
    start   = 1'b0;
    prog_we = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("busy_profile", 32'(busy_bad), 32'd0);
    tick();
    tick();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("pending_issues", 32'(exp_q.size()), 32'd0);
    chk("err_div0", 32'(err_div0), 32'(any_trap));
    check_results();
    stall_cfg = 0;
    stray_en  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0;
    bit found;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, issue_valid, err_div0, issue_opcode,
                              issue_operand1, issue_operand2}), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Full-depth program with prog_len above DEPTH (clamped, pc must not wrap)
    for (int i = 0; i < DEPTH; i++) load(i, 2'b00, 8'(i), 8'(2 * i + 1));
    run(31, 0, 1'b0, 1'b0);
    read_res(15, 8'd46);

    // Basic three-instruction program
    load(0, 2'b00, 8'd5, 8'd3);
    load(1, 2'b01, 8'd9, 8'd4);
    load(2, 2'b10, 8'd6, 8'd7);
    run(3, 0, 1'b0, 1'b0);
    read_res(0, 8'd8);
    read_res(1, 8'd5);
    read_res(2, 8'd42);
    read_res(3, 8'd10);

    // Zero-length program
    run(0, 0, 1'b0, 1'b0);

    // Backpressure, stray res_valid, start/prog_we pulses mid-run
    run(3, 4, 1'b1, 1'b1);
    run(3, 0, 1'b0, 1'b0);

    // Reset during WAIT of instruction 1, then replay
    for (int i = 0; i < 3; i++) exp_q.push_back(shadow[i]);
    prog_len = (AW+1)'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (issue_valid && issue_ready && issue_opcode == 2'b01) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_instr1", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("reset_midrun_outputs", 32'({busy, done, issue_valid, err_div0, issue_opcode,
                                     issue_operand1, issue_operand2}), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    run(3, 0, 1'b0, 1'b0);
    read_res(1, 8'd5);

    // Divide by zero, then a fresh start must clear the sticky flag
    load(0, 2'b11, 8'd8, 8'd0);
    load(1, 2'b11, 8'd8, 8'd2);
    run(2, 0, 1'b0, 1'b0);
    read_res(0, 8'hFF);
    read_res(1, 8'd4);
    load(0, 2'b00, 8'd1, 8'd1);
    run(1, 0, 1'b0, 1'b0);
    read_res(0, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
